// File: rtl/clk_period_monitor.sv
// Measures the period of an asynchronous slow clock in clk_in cycles and
// qualifies it: lock after consecutive in-tolerance periods, mismatch and stall flags.
`timescale 1ns/1ps
module clk_period_monitor #(
    parameter int EXPECTED_PERIOD = 8,
    parameter int TOLERANCE       = 0,
    parameter int LOCK_COUNT      = 4,
    parameter int TIMEOUT         = 32,
    parameter int CNT_W           = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             sig_in,
    output logic [CNT_W-1:0] period_out,
    output logic             period_valid,
    output logic             locked,
    output logic             mismatch,
    output logic             stall
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_MEASURE = 2'd1;
    localparam logic [1:0] ST_LOCKED  = 2'd2;

    localparam int MC_W = (LOCK_COUNT < 2) ? 1 : $clog2(LOCK_COUNT + 1);

    localparam logic [CNT_W-1:0] CNT_MAX = '1;
    localparam logic [CNT_W-1:0] EXP_C   = CNT_W'(EXPECTED_PERIOD);
    localparam logic [CNT_W-1:0] TOL_C   = CNT_W'(TOLERANCE);
    localparam logic [CNT_W-1:0] TMO_C   = CNT_W'(TIMEOUT);
    localparam logic [MC_W-1:0]  LOCK_C  = MC_W'(LOCK_COUNT);

    // sync_q[1:0] is the two-flop synchronizer, sync_q[2] holds the previous value for edge detect
    logic [2:0]       sync_q;
    logic [1:0]       state_q, state_d;
    logic [CNT_W-1:0] cnt_q, cnt_d;
    logic [MC_W-1:0]  match_cnt_q, match_cnt_d;
    logic [CNT_W-1:0] period_q, period_d;
    logic             valid_q, valid_d;
    logic             locked_q, locked_d;
    logic             mismatch_q, mismatch_d;
    logic             stall_q, stall_d;

    logic             edge_det;
    logic             cnt_sat;
    logic [CNT_W-1:0] diff;
    logic             is_match;
    logic [MC_W-1:0]  mc_inc;

    assign edge_det = sync_q[1] & ~sync_q[2];
    assign cnt_sat  = (cnt_q == CNT_MAX);
    // Subtract the smaller from the larger so a short period cannot wrap into a match
    assign diff     = (cnt_q >= EXP_C) ? (cnt_q - EXP_C) : (EXP_C - cnt_q);
    assign is_match = !cnt_sat && (diff <= TOL_C);
    assign mc_inc   = match_cnt_q + 1'b1;

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_sat ? cnt_q : cnt_q + 1'b1;
        match_cnt_d = match_cnt_q;
        period_d    = period_q;
        valid_d     = 1'b0;
        locked_d    = locked_q;
        mismatch_d  = 1'b0;
        stall_d     = stall_q;

        if (edge_det) begin
            // cnt_q holds the cycles since the previous edge; restart so the next read is P
            cnt_d = CNT_W'(1);
            case (state_q)
                ST_IDLE: begin
                    state_d     = ST_MEASURE;
                    stall_d     = 1'b0;
                    match_cnt_d = '0;
                end
                ST_MEASURE: begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (is_match) begin
                        if (mc_inc == LOCK_C) begin
                            state_d     = ST_LOCKED;
                            locked_d    = 1'b1;
                            match_cnt_d = '0;
                        end else begin
                            match_cnt_d = mc_inc;
                        end
                    end else begin
                        match_cnt_d = '0;
                    end
                end
                ST_LOCKED: begin
                    period_d = cnt_q;
                    valid_d  = 1'b1;
                    if (!is_match) begin
                        mismatch_d  = 1'b1;
                        locked_d    = 1'b0;
                        match_cnt_d = '0;
                        state_d     = ST_MEASURE;
                    end
                end
                default: begin
                    state_d     = ST_IDLE;
                    match_cnt_d = '0;
                end
            endcase
        end else if (cnt_q == TMO_C) begin
            // Edge takes priority, so a timeout only fires on an edge-free cycle
            stall_d     = 1'b1;
            locked_d    = 1'b0;
            match_cnt_d = '0;
            state_d     = ST_IDLE;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            sync_q      <= '0;
            state_q     <= ST_IDLE;
            cnt_q       <= '0;
            match_cnt_q <= '0;
            period_q    <= '0;
            valid_q     <= 1'b0;
            locked_q    <= 1'b0;
            mismatch_q  <= 1'b0;
            stall_q     <= 1'b0;
        end else begin
            sync_q      <= {sync_q[1:0], sig_in};
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            match_cnt_q <= match_cnt_d;
            period_q    <= period_d;
            valid_q     <= valid_d;
            locked_q    <= locked_d;
            mismatch_q  <= mismatch_d;
            stall_q     <= stall_d;
        end
    end

    assign period_out   = period_q;
    assign period_valid = valid_q;
    assign locked       = locked_q;
    assign mismatch     = mismatch_q;
    assign stall        = stall_q;

endmodule

// File: tb/tb_clk_period_monitor.sv
// Scoreboard bench for clk_period_monitor: each driven rising edge pushes the expected
// report, the monitor pops it when period_valid fires.
`timescale 1ns/1ps
module tb_clk_period_monitor;

    localparam int EXP_P = 8;
    localparam int TOL   = 1;
    localparam int LOCKN = 4;
    localparam int CW    = 16;

    logic          clk_in;
    logic          reset;
    logic          sig_in;
    logic [CW-1:0] period_out;
    logic          period_valid;
    logic          locked;
    logic          mismatch;
    logic          stall;

    clk_period_monitor #(
        .EXPECTED_PERIOD(EXP_P),
        .TOLERANCE      (TOL),
        .LOCK_COUNT     (LOCKN),
        .TIMEOUT        (32),
        .CNT_W          (CW)
    ) dut (
        .clk_in      (clk_in),
        .reset       (reset),
        .sig_in      (sig_in),
        .period_out  (period_out),
        .period_valid(period_valid),
        .locked      (locked),
        .mismatch    (mismatch),
        .stall       (stall)
    );

    typedef struct {
        int period;
        bit locked;
        bit mismatch;
    } exp_t;

    exp_t sb_q[$];
    int   n_checks = 0;
    int   n_errors = 0;
    bit   async_mode = 1'b0;
    int   async_valids = 0;

    // Behavioural expectation state
    bit   m_armed  = 1'b0;
    bit   m_locked = 1'b0;
    int   m_mc     = 0;
    int   m_prev   = 0;

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0d expected %0d at %0t", tag, got, exp, $time);
        end
    endtask

    task automatic wait_cyc(input int n);
        repeat (n) @(posedge clk_in);
        #1;
    endtask

    task automatic rise_edge();
        exp_t e;
        bit ok;
        sig_in = 1'b1;
        if (!m_armed) begin
            m_armed = 1'b1;
        end else begin
            ok = (m_prev >= EXP_P - TOL) && (m_prev <= EXP_P + TOL);
            e.period = m_prev;
            if (ok) begin
                if (!m_locked) begin
                    m_mc++;
                    if (m_mc == LOCKN) begin
                        m_locked = 1'b1;
                        m_mc = 0;
                    end
                end
                e.locked   = m_locked;
                e.mismatch = 1'b0;
            end else begin
                e.locked   = 1'b0;
                e.mismatch = m_locked;
                m_locked   = 1'b0;
                m_mc       = 0;
            end
            sb_q.push_back(e);
        end
    endtask

    task automatic pulse(input int p);
        rise_edge();
        wait_cyc(p / 2);
        sig_in = 1'b0;
        wait_cyc(p - p / 2);
        m_prev = p;
    endtask

    task automatic model_unarm();
        m_armed  = 1'b0;
        m_locked = 1'b0;
        m_mc     = 0;
    endtask

    always @(negedge clk_in) begin
        exp_t e;
        if (!reset) begin
            if (period_valid) begin
                $display("txn period=%0d locked=%0d mismatch=%0d", period_out, locked, mismatch);
                if (async_mode) begin
                    async_valids++;
                    chk("async_period_8_or_9", 32'(period_out == 8 || period_out == 9), 1);
                    chk("async_locked", locked, 1);
                    chk("async_mismatch", mismatch, 0);
                end else if (sb_q.size() == 0) begin
                    chk("unexpected_valid", period_valid, 0);
                end else begin
                    e = sb_q.pop_front();
                    chk("period", period_out, e.period);
                    chk("locked", locked, e.locked);
                    chk("mismatch", mismatch, e.mismatch);
                end
            end else begin
                chk("stray_mismatch", mismatch, 0);
            end
        end
    end

    initial begin
        reset  = 1'b1;
        sig_in = 1'b0;
        wait_cyc(3);
        chk("rst_period_out", period_out, 0);
        chk("rst_valid", period_valid, 0);
        chk("rst_locked", locked, 0);
        chk("rst_mismatch", mismatch, 0);
        chk("rst_stall", stall, 0);
        reset = 1'b0;

        // Constant input after reset: stall from IDLE
        wait_cyc(20);
        chk("idle_no_stall_yet", stall, 0);
        wait_cyc(16);
        chk("idle_stall", stall, 1);

        // Nominal periods, first edge only arms and clears stall
        pulse(8);
        chk("arm_clears_stall", stall, 0);
        repeat (5) pulse(8);
        chk("locked_after_4", locked, 1);

        // One long period while locked, then relock
        pulse(10);
        repeat (5) pulse(8);
        chk("relocked", locked, 1);

        // Tolerance edges 7 and 9 match, 6 misses
        pulse(10);
        pulse(7);
        pulse(9);
        pulse(8);
        pulse(9);
        pulse(6);
        repeat (5) pulse(8);
        chk("locked_before_stall", locked, 1);

        // Stall while locked
        rise_edge();
        wait_cyc(4);
        sig_in = 1'b0;
        wait_cyc(28);
        chk("stall_not_early", stall, 0);
        chk("locked_before_timeout", locked, 1);
        wait_cyc(4);
        chk("stall_set", stall, 1);
        chk("stall_unlocks", locked, 0);
        wait_cyc(4);
        model_unarm();
        pulse(8);
        chk("stall_cleared", stall, 0);
        repeat (4) pulse(8);
        chk("locked_after_stall", locked, 1);

        // Reset mid-period while locked
        rise_edge();
        wait_cyc(4);
        sig_in = 1'b0;
        wait_cyc(1);
        reset = 1'b1;
        wait_cyc(1);
        chk("midrst_period_out", period_out, 0);
        chk("midrst_valid", period_valid, 0);
        chk("midrst_locked", locked, 0);
        chk("midrst_mismatch", mismatch, 0);
        chk("midrst_stall", stall, 0);
        reset = 1'b0;
        wait_cyc(3);
        model_unarm();
        pulse(8);
        repeat (6) pulse(8);
        chk("locked_before_async", locked, 1);
        chk("sb_drained_sync", sb_q.size(), 0);

        // Asynchronous input at 8.3 clk_in cycles per period
        async_mode = 1'b1;
        repeat (20) begin
            sig_in = 1'b1;
            #41.5;
            sig_in = 1'b0;
            #41.5;
        end
        wait_cyc(6);
        chk("async_valid_count_ok", 32'(async_valids >= 19), 1);
        chk("async_still_locked", locked, 1);
        chk("sb_empty_end", sb_q.size(), 0);

        $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
        $finish;
    end

endmodule
